// File: rtl/gameconsole_pkg.sv
// Shared constants and types for the VRAM DMA engine: VRAM window, register map, FSM states.
package gameconsole_pkg;

  // VRAM window: 0x0600_0000 .. 0x063F_FFFF, selected by address bits [31:22].
  localparam logic [31:0] VRAM_BASE       = 32'h0600_0000;
  localparam logic [9:0]  VRAM_WINDOW_SEL = 10'h018;

  // Region selects (address bits [31:16]) inside the window.
  localparam logic [15:0] REGION_SPRITE  = 16'h0600;
  localparam logic [15:0] REGION_MAP     = 16'h0610;
  localparam logic [15:0] REGION_TILE    = 16'h0620;
  localparam logic [15:0] REGION_PALETTE = 16'h0630;

  // DMA register offsets.
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits.
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_CLR_DONE = 9;
  localparam int CTRL_CLR_ERR  = 10;

  // STATUS read bits.
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ERR    = 2;
  localparam int STAT_IRQ_EN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } dma_state_t;

  // True when a (possibly overflowed, hence 64-bit) address lies in the VRAM window.
  function automatic logic in_vram_window(input logic [63:0] addr);
    return addr[63:22] == {32'd0, VRAM_WINDOW_SEL};
  endfunction

endpackage

// File: rtl/vram_dma_if.sv
// Source read port and VRAM write port of the DMA engine, bundled as one bus.
interface vram_dma_if;
  logic        src_req;
  logic [31:0] src_addr;
  logic        src_ack;
  logic [31:0] src_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;

  // The DMA engine side.
  modport master (
    output src_req, src_addr, mem_en, mem_we, mem_addr, mem_din,
    input  src_ack, src_rdata
  );

  // The memory side (system memory read port plus VRAM port).
  modport slave (
    input  src_req, src_addr, mem_en, mem_we, mem_addr, mem_din,
    output src_ack, src_rdata
  );
endinterface

// File: rtl/vram_dma.sv
// Word-granular DMA from a system-memory read port into VRAM, sharing the VRAM
// port with the CPU (CPU stalled only in DMA write cycles).
module vram_dma
  import gameconsole_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_en,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_din,
  output logic [31:0] cfg_dout,
  vram_dma_if.master  bus,
  input  logic        cpu_mem_en,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_din,
  output logic        cpu_stall,
  output logic        irq
);

  dma_state_t state_reg, state_next;

  logic [31:0]      src_reg, dst_reg;
  logic [LEN_W-1:0] len_reg;
  logic             irq_en_reg, done_reg, err_reg, abort_reg;
  logic [31:0]      work_src_reg, work_dst_reg, data_reg;
  logic [LEN_W-1:0] work_cnt_reg;

  logic busy, cfg_wr, ctrl_wr, start_req, abort_req, abort_any;
  logic range_ok;
  logic [63:0] last_addr;

  // FSM strobes toward the datapath.
  logic load, zero_done, range_fail, latch, advance, finish;

  assign busy      = (state_reg != ST_IDLE);
  assign cfg_wr    = cfg_en & cfg_we;
  assign ctrl_wr   = cfg_wr && (cfg_addr == REG_CTRL);
  assign start_req = ctrl_wr & cfg_din[CTRL_START];
  assign abort_req = ctrl_wr & cfg_din[CTRL_ABORT];
  assign abort_any = abort_reg | abort_req;
  assign irq       = done_reg & irq_en_reg;

  // Last destination word computed in 64 bits so a wrap past 2**32 cannot look in-window.
  assign last_addr = {32'd0, dst_reg} + (64'(len_reg) - 64'd1) * 64'(ADDR_STEP);
  assign range_ok  = in_vram_window({32'd0, dst_reg}) && in_vram_window(last_addr);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state, datapath strobes and port arbitration.
  always_comb begin
    state_next   = state_reg;
    load         = 1'b0;
    zero_done    = 1'b0;
    range_fail   = 1'b0;
    latch        = 1'b0;
    advance      = 1'b0;
    finish       = 1'b0;
    bus.src_req  = 1'b0;
    bus.src_addr = work_src_reg;
    bus.mem_en   = cpu_mem_en;
    bus.mem_we   = cpu_mem_we;
    bus.mem_addr = cpu_mem_addr;
    bus.mem_din  = cpu_mem_din;
    cpu_stall    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_req) begin
          load = 1'b1;
          if (len_reg == '0)  zero_done  = 1'b1;
          else if (!range_ok) range_fail = 1'b1;
          else                state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        bus.src_req = 1'b1;
        if (bus.src_ack) begin
          if (abort_any) begin
            state_next = ST_IDLE;
          end else begin
            latch      = 1'b1;
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = work_dst_reg;
        bus.mem_din  = data_reg;
        cpu_stall    = cpu_mem_en;
        advance      = 1'b1;
        if (abort_any) begin
          state_next = ST_IDLE;
        end else if (work_cnt_reg == LEN_W'(1)) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Programming registers, status flags and the working counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg      <= '0;
      dst_reg      <= '0;
      len_reg      <= '0;
      irq_en_reg   <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      abort_reg    <= 1'b0;
      work_src_reg <= '0;
      work_dst_reg <= '0;
      work_cnt_reg <= '0;
      data_reg     <= '0;
    end else begin
      if (cfg_wr && cfg_addr == REG_SRC && !busy) src_reg <= cfg_din;
      if (cfg_wr && cfg_addr == REG_DST && !busy) dst_reg <= cfg_din;
      if (cfg_wr && cfg_addr == REG_LEN && !busy) len_reg <= cfg_din[LEN_W-1:0];
      if (ctrl_wr) begin
        irq_en_reg <= cfg_din[CTRL_IRQ_EN];
        if (cfg_din[CTRL_CLR_DONE]) done_reg <= 1'b0;
        if (cfg_din[CTRL_CLR_ERR])  err_reg  <= 1'b0;
      end
      // A start overrides any clear written alongside it.
      if (load) begin
        work_src_reg <= src_reg;
        work_dst_reg <= dst_reg;
        work_cnt_reg <= len_reg;
        done_reg     <= zero_done | range_fail;
        err_reg      <= range_fail;
      end
      if (latch) data_reg <= bus.src_rdata;
      if (advance) begin
        work_cnt_reg <= work_cnt_reg - LEN_W'(1);
        work_src_reg <= work_src_reg + 32'(ADDR_STEP);
        work_dst_reg <= work_dst_reg + 32'(ADDR_STEP);
      end
      if (finish) done_reg <= 1'b1;
      // Abort is remembered until the FSM is back in IDLE.
      if (state_next == ST_IDLE)  abort_reg <= 1'b0;
      else if (abort_req && busy) abort_reg <= 1'b1;
    end
  end

  // Register read mux; reflects pre-edge state.
  always_comb begin
    cfg_dout = '0;
    case (cfg_addr)
      REG_SRC: cfg_dout = src_reg;
      REG_DST: cfg_dout = dst_reg;
      REG_LEN: cfg_dout = 32'(len_reg);
      default: begin
        cfg_dout[STAT_BUSY]   = busy;
        cfg_dout[STAT_DONE]   = done_reg;
        cfg_dout[STAT_ERR]    = err_reg;
        cfg_dout[STAT_IRQ_EN] = irq_en_reg;
      end
    endcase
  end

endmodule

// File: tb/tb_vram_dma.sv
// Randomized scoreboard bench for vram_dma: expected VRAM writes are queued when a
// transfer is started and a monitor compares every write seen on the VRAM port.
module tb_vram_dma;
  import gameconsole_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en, cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_din, cfg_dout;
  logic        cpu_mem_en, cpu_mem_we, cpu_stall, irq;
  logic [31:0] cpu_mem_addr, cpu_mem_din;

  vram_dma_if bus();

  vram_dma #(.LEN_W(16), .ADDR_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .bus(bus),
    .cpu_mem_en(cpu_mem_en), .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_din(cpu_mem_din), .cpu_stall(cpu_stall), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_delay = 0;
  int src_req_cycles = 0;
  int cpu_fwd_cnt = 0;
  int cpu_issued = 0;
  bit cpu_run = 0;
  bit cpu_fwd_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Source memory contents: a fixed hash of the word address.
  function automatic logic [31:0] src_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Destination range rule: first and last word inside 0x0600_0000..0x063F_FFFF.
  function automatic bit model_range_ok(input logic [31:0] d, input int len);
    longint first, last;
    first = longint'(d);
    last  = first + longint'(len - 1) * 4;
    return first >= 64'h0600_0000 && last < 64'h0640_0000;
  endfunction

  // Source port responder: ack after ack_delay extra cycles, checking address hold.
  initial begin : responder
    int wcnt;
    logic [31:0] held;
    wcnt = 0; held = '0;
    bus.src_ack = 1'b0;
    bus.src_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.src_req && !rst) begin
        if (wcnt > 0) chk("src_addr_hold", bus.src_addr, held);
        else held = bus.src_addr;
        if (wcnt == ack_delay) begin
          bus.src_ack = 1'b1;
          bus.src_rdata = src_word(bus.src_addr);
          wcnt = 0;
        end else begin
          bus.src_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.src_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // CPU: writes to 0x0610_0010 every cycle while cpu_run, retrying stalled accesses.
  initial begin : cpu_driver
    logic [31:0] next_data;
    next_data = 32'hC000_0000;
    cpu_mem_en = 1'b0; cpu_mem_we = 1'b0; cpu_mem_addr = '0; cpu_mem_din = '0;
    forever begin
      @(posedge clk); #1;
      if (cpu_mem_en && !cpu_fwd_last) begin
        // stalled last cycle: hold the access
      end else if (cpu_run) begin
        cpu_mem_en = 1'b1; cpu_mem_we = 1'b1;
        cpu_mem_addr = 32'h0610_0010;
        cpu_mem_din = next_data;
        next_data++;
        cpu_issued++;
      end else begin
        cpu_mem_en = 1'b0; cpu_mem_we = 1'b0; cpu_mem_addr = '0; cpu_mem_din = '0;
      end
    end
  end

  // Monitor: classify every VRAM-port cycle as CPU forward or DMA write and compare.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.src_req) src_req_cycles++;
      cpu_fwd_last = 1'b0;
      if (cpu_mem_en && !cpu_stall) begin
        chk("cpu_fwd_en_we", {30'd0, bus.mem_en, bus.mem_we}, {30'd0, 1'b1, cpu_mem_we});
        chk("cpu_fwd_addr", bus.mem_addr, cpu_mem_addr);
        chk("cpu_fwd_din", bus.mem_din, cpu_mem_din);
        cpu_fwd_cnt++;
        cpu_fwd_last = 1'b1;
      end else if (bus.mem_en) begin
        chk("dma_mem_we", {31'd0, bus.mem_we}, 32'd1);
        chk("cpu_stall_in_write", {31'd0, cpu_stall}, {31'd0, cpu_mem_en});
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dma_unexpected_write: got addr %h data %h, expected no write", bus.mem_addr, bus.mem_din);
        end else begin
          e = exp_q.pop_front();
          chk("dma_addr", bus.mem_addr, e.addr);
          chk("dma_data", bus.mem_din, e.data);
          $display("dma write [%h] <= %h (cycle %0d)", bus.mem_addr, bus.mem_din, cyc);
        end
      end else if (cpu_stall) begin
        chk("stall_without_write", {31'd0, cpu_stall}, 32'd0);
      end
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_din = v;
    @(posedge clk); #1;
    cfg_en = 1'b0; cfg_we = 1'b0; cfg_din = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    cfg_addr = a;
    #1 v = cfg_dout;
  endtask

  task automatic wait_cpu_idle();
    for (int k = 0; k < 50 && cpu_mem_en; k++) @(negedge clk);
    chk("cpu_idle_timeout", {31'd0, cpu_mem_en}, 32'd0);
    chk("cpu_fwd_count", cpu_fwd_cnt, cpu_issued);
  endtask

  // One full transfer with expected writes, timing, status and irq checks.
  task automatic run_transfer(input logic [31:0] s, input logic [31:0] d, input int len,
                              input int dly, input bit cpu);
    bit ok, got;
    int t0, base_src;
    logic [31:0] st;
    wr_t w;
    ack_delay = dly;
    cfg_write(REG_SRC, s);
    cfg_write(REG_DST, d);
    cfg_write(REG_LEN, len);
    ok = model_range_ok(d, len);
    if (len > 0 && ok)
      for (int i = 0; i < len; i++) begin
        w.addr = d + 32'(4 * i);
        w.data = src_word(s + 32'(4 * i));
        exp_q.push_back(w);
      end
    $display("transfer src=%h dst=%h len=%0d delay=%0d cpu=%0d", s, d, len, dly, cpu);
    cpu_run = cpu;
    base_src = src_req_cycles;
    cfg_write(REG_CTRL, 32'h3);
    if (len > 0 && ok) begin
      chk("start_src_req", {31'd0, bus.src_req}, 32'd1);
      t0 = cyc; got = 0;
      for (int k = 0; k < 2000 && !got; k++) begin
        @(negedge clk);
        if (irq) got = 1;
      end
      if (!got) begin
        n_checks++; n_fail++;
        $display("FAIL irq_timeout: got irq 0 expected 1 within 2000 cycles");
      end else begin
        chk("done_latency", cyc - t0, len * (dly + 2));
      end
    end else begin
      @(negedge clk);
      chk("no_src_req", src_req_cycles - base_src, 0);
    end
    cpu_run = 0;
    wait_cpu_idle();
    cfg_read(REG_CTRL, st);
    chk("status_after", st, (len > 0 && !ok) ? 32'hE : 32'hA);
    chk("irq_after", {31'd0, irq}, 32'd1);
    chk("queue_drained", exp_q.size(), 0);
    cfg_write(REG_CTRL, 32'h602);
    cfg_read(REG_CTRL, st);
    chk("status_cleared", st, 32'h8);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
  endtask

  initial begin : main
    logic [31:0] v;
    int base_src, len;
    logic [31:0] d;
    wr_t w;
    rst = 1'b1; cfg_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_src_req", {31'd0, bus.src_req}, 32'd0);
    chk("reset_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), v);
      chk("reset_reg", v, 32'd0);
    end

    // Directed: back-to-back acks, delayed acks, range error, zero length, CPU contention.
    run_transfer(32'h100, 32'h0620_0000, 4, 0, 0);
    run_transfer(32'h100, 32'h0620_0000, 4, 3, 0);
    run_transfer(32'h100, 32'h063F_FFFC, 2, 0, 0);
    run_transfer(32'h100, 32'h0600_0000, 0, 0, 0);
    run_transfer(32'h200, 32'h0630_0000, 5, 0, 1);
    run_transfer(32'h240, 32'h0600_0040, 3, 2, 1);

    // Abort while FETCH waits on ack: request held through ack, no write.
    ack_delay = 5;
    cfg_write(REG_SRC, 32'h300);
    cfg_write(REG_DST, 32'h0600_0100);
    cfg_write(REG_LEN, 32'd4);
    base_src = src_req_cycles;
    cfg_write(REG_CTRL, 32'h3);
    cfg_write(REG_CTRL, 32'h6);
    chk("abort_src_req_held", {31'd0, bus.src_req}, 32'd1);
    for (int k = 0; k < 50 && bus.src_req; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("abort_fetch_cycles", src_req_cycles - base_src, 6);
    cfg_read(REG_CTRL, v);
    chk("abort_status", v, 32'h8);
    $display("abort during fetch complete");
    run_transfer(32'h300, 32'h0600_0100, 4, 0, 0);

    // Reset in the middle of a transfer.
    ack_delay = 1;
    cfg_write(REG_SRC, 32'h400);
    cfg_write(REG_DST, 32'h0610_0000);
    cfg_write(REG_LEN, 32'd6);
    for (int i = 0; i < 6; i++) begin
      w.addr = 32'h0610_0000 + 32'(4 * i);
      w.data = src_word(32'h400 + 32'(4 * i));
      exp_q.push_back(w);
    end
    cfg_write(REG_CTRL, 32'h3);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_src_req", {31'd0, bus.src_req}, 32'd0);
    chk("midrst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("midrst_mem_addr", bus.mem_addr, 32'd0);
    chk("midrst_mem_din", bus.mem_din, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    chk("midrst_cfg_dout", cfg_dout, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), v);
      chk("midrst_reg", v, 32'd0);
    end
    repeat (10) @(negedge clk);
    $display("reset mid-transfer complete");

    // Randomized transfers.
    for (int it = 0; it < 12; it++) begin
      len = int'($urandom_range(1, 8));
      if ($urandom_range(0, 3) == 0)
        d = 32'h0640_0000 - 32'(4 * (len - 1)) + 32'h4;
      else
        d = 32'h0600_0000 + ($urandom_range(0, 32'h000F_FFF0) << 2);
      run_transfer($urandom & 32'hFFFF_FFFC, d, len, int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_dma.md
# vram_dma

Word-granular DMA engine that sits directly upstream of the VRAM block's CPU-side port. It copies a block of 32-bit words from a system-memory read port into the sprite, map, tile or palette regions (0x0600_0000–0x063F_FFFF) and shares that port with the CPU, which is stalled while the engine owns it. It is programmed through a small register window and signals completion with a level interrupt.

## Interface
- LEN_W, default 16: width of the word-count register; maximum transfer is 2**LEN_W-1 words.
- ADDR_STEP, default 4: increment applied to the source and destination addresses after each word.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cfg_en, cfg_we  in  1 each  register access strobe and write enable.
- cfg_addr  in  2  register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS.
- cfg_din  in  32  register write data.
- cfg_dout  out  32  register read data, combinational from cfg_addr.
- src_req  out  1  source read request.
- src_addr  out  32  source word address.
- src_ack  in  1  source read accepted; src_rdata is valid in the same cycle.
- src_rdata  in  32  source read data.
- cpu_mem_en, cpu_mem_we  in  1 each  CPU VRAM access.
- cpu_mem_addr, cpu_mem_din  in  32 each  CPU VRAM address and write data.
- cpu_stall  out  1  CPU must hold its access and retry.
- mem_en, mem_we  out  1 each  to the VRAM port.
- mem_addr, mem_din  out  32 each  to the VRAM port.
- irq  out  1  done & irq_en.

## Operation
- **Registers.** SRC, DST and LEN are read/write. CTRL write: bit0 start, bit1 irq_en (stored), bit2 abort. STATUS read: bit0 busy, bit1 done, bit2 err, bit3 irq_en. Writing 1 to cfg_din[9] or cfg_din[10] on CTRL clears done or err respectively.
- **Writes while busy.** Writes to SRC, DST and LEN are ignored while busy. Start is ignored while busy.
- **FSM states.** IDLE, FETCH, WRITE.
- **IDLE to FETCH.** Start in IDLE copies SRC, DST and LEN into working counters and clears done and err. If LEN is nonzero and the range check passes, the FSM moves to FETCH.
- **Range check.** DST[31:22] must equal 10'h018 (0x0600_0000–0x063F_FFFF), and DST + (LEN-1)*ADDR_STEP must remain in that window. On failure: set err and done, make no accesses, stay in IDLE.
- **LEN = 0.** Done is set the next cycle with no accesses.
- **FETCH.** Hold src_req high with src_addr stable until src_ack. On ack, latch src_rdata and go to WRITE.
- **WRITE.** Drive mem_en = mem_we = 1 with the working address and latched data for exactly one cycle. Then decrement the count and advance both addresses by ADDR_STEP. If the count reaches 0, set done and go to IDLE; otherwise go to FETCH.
- **Abort.** Abort in WRITE finishes the current write, then goes to IDLE. Abort in FETCH keeps src_req asserted until ack, discards the data, then goes to IDLE. Done is not set on abort; busy deasserts on return to IDLE.
- **Port arbitration.** In WRITE the DMA owns the VRAM port. If cpu_mem_en is high in that cycle, cpu_stall = 1 and nothing from the CPU is forwarded. In all other cycles cpu_mem_* pass combinationally to mem_* and cpu_stall = 0. The CPU reads mem_dout from VRAM directly.
- **Address arithmetic.** 32-bit with wrap-around. Overflow cannot reach VRAM because of the range check.

## Timing
- **Reset.** All outputs are 0, registers are 0, FSM is in IDLE. Reset mid-transfer stops the transfer immediately with no further accesses.
- **Start latency.** The cycle after the start write, busy = 1 and src_req = 1.
- **Throughput.** Best case is 2 cycles/word (ack in the first FETCH cycle); an N-word transfer takes 2N cycles from the first src_req to the done rise.
- **Done and irq.** Done rises the cycle after the last write; irq follows done in the same cycle.
- **Simultaneous events.** A start write and a done-clear in the same CTRL write: start wins and done ends cleared. A register read in the cycle state changes returns the pre-edge value.

## Structure
- **Shared package (gameconsole_pkg):**
  - VRAM window constants (base 0x0600_0000 and region selects 0x0600, 0x0610, 0x0620, 0x0630);
  - DMA register offsets and CTRL/STATUS bit positions;
  - the state enum typedef dma_state_t.
- **Module partitioning:** a single module with no sub-module. The register file, FSM and mux are too small to split.

## Test plan
- SRC = 0x100, DST = 0x0620_0000, LEN = 4, ack every cycle, irq_en = 1 -> four VRAM writes at 0x0620_0000/04/08/0C with the source data in order; done and irq rise 8 cycles after the first src_req.
- Same transfer with src_ack delayed 3 cycles per word -> src_req and src_addr held stable throughout, no duplicate writes, identical VRAM contents.
- DST = 0x063F_FFFC, LEN = 2 -> err = 1, done = 1, no src_req and no mem_en; LEN = 0 -> done only, no accesses.
- CPU write to 0x0610_0010 on every cycle during a transfer -> cpu_stall only in WRITE cycles; each CPU write is forwarded on a non-WRITE cycle and the DMA data is intact.
- Abort while FETCH is waiting on ack -> src_req held until ack, no write, busy drops; a later start runs normally.
- rst asserted mid-transfer -> all outputs 0 the next cycle and registers read 0.
